// File: rtl/channel_merge_arbiter_if.sv
// ----------------------------------------------------------------------------
// channel_merge_arbiter_if : capture-side and stream-side signals of the merge
// arbiter. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface channel_merge_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int PORTS = 4
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS*WIDTH-1:0] in_data;
  logic [PORTS-1:0]       in_valid;
  logic [WIDTH-1:0]       out_data;
  logic [PW-1:0]          out_port;
  logic                   out_valid;
  logic                   out_ready;
  logic [PORTS-1:0]       pending;
  logic                   overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_port, out_valid, pending, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_port, out_valid, pending, overflow
  );
endinterface

`default_nettype wire

// File: rtl/channel_merge_arbiter.sv
// ----------------------------------------------------------------------------
// channel_merge_arbiter : per-port holding slots for unstallable pulses,
// drained round-robin onto one valid/ready stream. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module channel_merge_arbiter #(
  parameter int WIDTH = 8,
  parameter int PORTS = 4
) (
  input  wire clk,
  input  wire reset,
  input  wire initialize,
  channel_merge_arbiter_if.slave bus
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PORTS-1:0] full_q, full_d;
  logic [WIDTH-1:0] data_q [PORTS];
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    scan_idx;
  logic [PW:0]      idx_sum;
  logic [PW-1:0]    gnt_w;
  logic             valid_w;
  logic             xfer_w;
  logic             drain_w;

  // Walk from the farthest candidate back to rr_q so the nearest full slot wins.
  always_comb begin
    scan_idx = rr_q;
    idx_sum  = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_q} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(PORTS)) idx_sum = idx_sum - (PW+1)'(PORTS);
      if (full_q[idx_sum[PW-1:0]]) scan_idx = idx_sum[PW-1:0];
    end
  end

  assign gnt_w   = (state_q == S_HOLD) ? gnt_q : scan_idx;
  assign valid_w = (state_q == S_HOLD) | (|full_q);
  assign xfer_w  = valid_w & bus.out_ready;

  assign bus.out_valid = valid_w;
  assign bus.out_port  = gnt_w;
  assign bus.out_data  = data_q[gnt_w];
  assign bus.pending   = full_q;
  assign bus.overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    drain_w = 1'b0;

    for (int i = 0; i < PORTS; i++) begin
      drain_w = xfer_w && (gnt_w == PW'(i));
      if (bus.in_valid[i]) begin
        full_d[i] = 1'b1;
        if (full_q[i] && !drain_w) ovf_d = 1'b1;
      end else if (drain_w) begin
        full_d[i] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (valid_w && !bus.out_ready) begin
          state_d = S_HOLD;
          gnt_d   = gnt_w;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer_w) rr_d = (gnt_w == PW'(PORTS - 1)) ? '0 : gnt_w + 1'b1;

    if (initialize) begin
      state_d = S_IDLE;
      full_d  = '0;
      ovf_d   = 1'b0;
      rr_d    = '0;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Slot payloads carry no reset; a stale payload is invisible while its full bit is clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (bus.in_valid[i] && reset && !initialize)
        data_q[i] <= bus.in_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_channel_merge_arbiter.sv
// ----------------------------------------------------------------------------
// tb_channel_merge_arbiter : directed scenarios plus randomized traffic checked
// against a slot-level reference model. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_channel_merge_arbiter;
  localparam int WIDTH = 8;
  localparam int PORTS = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic initialize = 1'b0;

  channel_merge_arbiter_if #(.WIDTH(WIDTH), .PORTS(PORTS)) bus ();

  channel_merge_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS)) dut (
    .clk        (clk),
    .reset      (reset),
    .initialize (initialize),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slots, pointer, held grant, sticky flag.
  bit             m_full [PORTS];
  logic [WIDTH-1:0] m_data [PORTS];
  int             m_rr;
  bit             m_lock;
  int             m_gnt;
  bit             m_ovf;

  function automatic bit m_valid();
    bit any = 0;
    for (int p = 0; p < PORTS; p++) any |= m_full[p];
    return m_lock || any;
  endfunction

  function automatic int m_sel();
    if (m_lock) return m_gnt;
    for (int k = 0; k < PORTS; k++)
      if (m_full[(m_rr + k) % PORTS]) return (m_rr + k) % PORTS;
    return m_rr;
  endfunction

  function automatic logic [PORTS-1:0] m_pending();
    logic [PORTS-1:0] v = '0;
    for (int p = 0; p < PORTS; p++) v[p] = m_full[p];
    return v;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < PORTS; p++) m_full[p] = 0;
    m_rr = 0; m_lock = 0; m_gnt = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit v;
    int g;
    bit xfer;
    v = m_valid();
    g = m_sel();
    xfer = v && bus.out_ready;
    if (!reset || initialize) begin
      model_clear();
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (bus.in_valid[p]) begin
          if (m_full[p] && !(xfer && g == p)) m_ovf = 1;
          m_full[p] = 1;
          m_data[p] = bus.in_data[p*WIDTH +: WIDTH];
        end else if (xfer && g == p) begin
          m_full[p] = 0;
        end
      end
      if (xfer) begin
        m_lock = 0;
        m_rr = (g + 1) % PORTS;
      end else if (v) begin
        m_lock = 1;
        m_gnt = g;
      end
    end
  endtask

  // Advance one clock: model and DUT see the same inputs, pulses then drop.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    initialize = 1'b0;
  endtask

  task automatic pulse(input int p, input logic [WIDTH-1:0] d);
    bus.in_valid[p] = 1'b1;
    bus.in_data[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = '1;
    bus.in_data = $urandom;
    model_step(); @(posedge clk); #1;
    bus.in_valid = '1;
    model_step(); @(posedge clk); #1;
    bus.in_valid = '0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    n_checks++; if (bus.out_port !== 2'd0) begin n_fail++; $display("FAIL reset_port got=%0d exp=0", bus.out_port); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    pulse(2, 8'hA5);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_port !== 2'd2) begin n_fail++; $display("FAIL single_port got=%0d exp=2", bus.out_port); end
    n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bus.out_data); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    bus.out_ready = 1'b1;
    for (int p = 0; p < PORTS; p++) pulse(p, 8'h10 + 8'(p));
    tick();
    for (int p = 0; p < PORTS; p++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_port !== 2'(p)) begin
        n_fail++; $display("FAIL fair_port[%0d] got=%0d valid=%b exp=%0d", p, bus.out_port, bus.out_valid, p);
      end
      n_checks++; if (bus.out_data !== 8'h10 + 8'(p)) begin
        n_fail++; $display("FAIL fair_data[%0d] got=%h exp=%h", p, bus.out_data, 8'h10 + 8'(p));
      end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_rotation();
    bit captured = 0;
    bit seen = 0;
    int xfers = 0;
    int seen_at = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      if (captured && bus.out_valid && bus.out_ready) begin
        xfers++;
        if (bus.out_port == 2'd3) begin seen = 1; seen_at = xfers; end
      end
      pulse(0, 8'(cyc));
      if (cyc == 1) pulse(3, 8'h33);
      tick();
      if (cyc == 1) captured = 1;
    end
    n_checks++; if (!seen || seen_at > 2) begin
      n_fail++; $display("FAIL rotation_port3 seen=%0d at_transfer=%0d exp_within=2", seen, seen_at);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.out_ready = 1'b0;
    pulse(1, 8'h01);
    tick();
    pulse(1, 8'h02);
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag[%0d] got=%b exp=1", c, bus.overflow); end
      n_checks++; if (bus.out_data !== 8'h02) begin n_fail++; $display("FAIL ovf_data[%0d] got=%h exp=02", c, bus.out_data); end
      n_checks++; if (bus.out_port !== 2'd1) begin n_fail++; $display("FAIL ovf_port[%0d] got=%0d exp=1", c, bus.out_port); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_same_edge_drain();
    int xfers = 0;
    logic [WIDTH-1:0] seq [2];
    do_reset();
    bus.out_ready = 1'b1;
    pulse(1, 8'h5A);
    tick();
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        if (xfers < 2) seq[xfers] = bus.out_data;
        xfers++;
      end
      if (c == 0) pulse(1, 8'hC3);
      tick();
    end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL drain_ovf got=%b exp=0", bus.overflow); end
    n_checks++; if (xfers != 2) begin n_fail++; $display("FAIL drain_count got=%0d exp=2", xfers); end
    n_checks++; if (seq[0] !== 8'h5A || seq[1] !== 8'hC3) begin
      n_fail++; $display("FAIL drain_order got=%h,%h exp=5a,c3", seq[0], seq[1]);
    end
  endtask

  task automatic test_initialize();
    do_reset();
    bus.out_ready = 1'b1;
    pulse(1, 8'h77);
    tick();
    tick();
    bus.out_ready = 1'b0;
    pulse(0, 8'hE0); pulse(2, 8'hE2); pulse(3, 8'hE3);
    tick();
    pulse(2, 8'hF2);
    tick();
    n_checks++; if (bus.overflow !== 1'b1 || bus.out_port !== 2'd2) begin
      n_fail++; $display("FAIL init_pre ovf=%b port=%0d exp ovf=1 port=2", bus.overflow, bus.out_port);
    end
    initialize = 1'b1;
    pulse(1, 8'h99);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL init_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL init_pending got=%b exp=0000", bus.pending); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL init_overflow got=%b exp=0", bus.overflow); end
    pulse(0, 8'hA0); pulse(3, 8'hA3);
    tick();
    n_checks++; if (bus.out_port !== 2'd0 || bus.out_data !== 8'hA0) begin
      n_fail++; $display("FAIL init_next_grant port=%0d data=%h exp port=0 data=a0", bus.out_port, bus.out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      n_checks++; if (bus.out_valid !== m_valid()) begin
        n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, bus.out_valid, m_valid());
      end
      n_checks++; if (bus.pending !== m_pending() || bus.overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_state[%0d] pending=%b ovf=%b exp pending=%b ovf=%b", c, bus.pending, bus.overflow, m_pending(), m_ovf);
      end
      if (m_valid()) begin
        n_checks++; if (bus.out_port !== 2'(m_sel()) || bus.out_data !== m_data[m_sel()]) begin
          n_fail++; $display("FAIL rand_grant[%0d] port=%0d data=%h exp port=%0d data=%h", c, bus.out_port, bus.out_data, m_sel(), m_data[m_sel()]);
        end
      end
      bus.in_valid  = 4'($urandom) & 4'($urandom);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      initialize    = ($urandom_range(0, 99) == 0);
      tick();
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_overflow();
    test_same_edge_drain();
    test_initialize();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
